dmem_responder: RTL and testbench

- Data-side memory responder for the CPU's data SRAM-like bus.
- Accepts load/store requests from the memory stage: word address, byte-lane write strobes, access size.
- Returns full 32-bit read words; the memory stage does byte/halfword extraction and sign extension.
- Used as the on-chip data RAM in simulation and FPGA builds. Responds in order, with configurable fixed latency and a small outstanding-request queue.

---
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// On-chip data RAM for the CPU memory stage. Each accepted request is executed
// against the array at once. Its response then waits in a small in-order queue for a fixed latency.
module dmem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic        addr_ok_o,
  output logic        data_ok_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  localparam logic [3:0]       TIMER_INIT = 4'(LATENCY - 1);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(QDEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(QDEPTH);

  logic [31:0] mem_q [2**ADDR_W];

  logic [31:0]      qdata_q [QDEPTH];
  logic             qerr_q  [QDEPTH];
  logic [3:0]       timer_q [QDEPTH];
  logic [3:0]       timer_d [QDEPTH];
  logic [QDEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        data_ok_q, data_ok_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic              accept;
  logic              pop;
  logic              err_c;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       entry_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Space freed by a retire only shows up after the retiring edge, because count_q is registered.
  assign addr_ok_o = !rst_i && (count_q < CNT_FULL);
  assign accept    = req_i && addr_ok_o;
  assign word_idx  = addr_i[ADDR_W+1:2];
  assign pop       = valid_q[head_q] && (timer_q[head_q] == 4'd0);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    err_c = (addr_i >> (ADDR_W + 2)) != 32'd0;
    if (size_i == 2'd1 && addr_i[0]) err_c = 1'b1;
    if (size_i[1] && addr_i[1:0] != 2'b00) err_c = 1'b1;
  end

  assign entry_data = (wr_i || err_c) ? 32'd0 : mem_q[word_idx];

  // NOTE: the RAM array and queue payloads have no reset. Only the control state needs a known value.
  always_ff @(posedge clk_i) begin
    if (accept && wr_i && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem_q[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      qdata_q[tail_q] <= entry_data;
      qerr_q[tail_q]  <= err_c;
    end
  end

  always_comb begin
    valid_d = valid_q;
    timer_d = timer_q;
    head_d  = head_q;
    tail_d  = tail_q;
    for (int i = 0; i < QDEPTH; i++) begin
      if (valid_q[i] && timer_q[i] != 4'd0) timer_d[i] = timer_q[i] - 4'd1;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end
    if (accept) begin
      valid_d[tail_q] = 1'b1;
      timer_d[tail_q] = TIMER_INIT;
      tail_d          = ptr_inc(tail_q);
    end
    count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
  end

  always_comb begin
    data_ok_d = pop;
    rdata_d   = rdata_q;
    err_d     = err_q;
    if (pop) begin
      rdata_d = qdata_q[head_q];
      err_d   = qerr_q[head_q];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) timer_q[i] <= 4'd0;
    end else begin
      valid_q   <= valid_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      for (int i = 0; i < QDEPTH; i++) timer_q[i] <= timer_d[i];
    end
  end

  assign data_ok_o = data_ok_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Three responder instances with different latency and depth share one request bus.
// A per-instance model predicts addr_ok and each response cycle from acceptance times.
module tb_dmem_responder;

  localparam int NI     = 3;
  localparam int ADDR_W = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;

  logic        addr_ok [NI];
  logic        data_ok [NI];
  logic [31:0] rdata   [NI];
  logic        err     [NI];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(2), .QDEPTH(2)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .wr_i(wr), .size_i(size), .addr_i(addr),
    .wdata_i(wdata), .wstrb_i(wstrb), .addr_ok_o(addr_ok[0]), .data_ok_o(data_ok[0]),
    .rdata_o(rdata[0]), .err_o(err[0]));

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(1), .QDEPTH(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .wr_i(wr), .size_i(size), .addr_i(addr),
    .wdata_i(wdata), .wstrb_i(wstrb), .addr_ok_o(addr_ok[1]), .data_ok_o(data_ok[1]),
    .rdata_o(rdata[1]), .err_o(err[1]));

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(5), .QDEPTH(3)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .wr_i(wr), .size_i(size), .addr_i(addr),
    .wdata_i(wdata), .wstrb_i(wstrb), .addr_ok_o(addr_ok[2]), .data_ok_o(data_ok[2]),
    .rdata_o(rdata[2]), .err_o(err[2]));

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  function automatic int qd_of(input int k);
    return (k == 2) ? 3 : 2;
  endfunction

  // Reference model: RAM image plus a list of pending responses, each with the edge it becomes due
  logic [31:0] mmem   [NI][16];
  logic [31:0] f_data [NI][8];
  logic        f_err  [NI][8];
  int          f_due  [NI][8];
  int          f_hd   [NI];
  int          f_cnt  [NI];
  logic        exp_dok   [NI];
  logic [31:0] exp_rdata [NI];
  logic        exp_err   [NI];
  int          edge_no = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  function automatic logic spec_err(input logic [31:0] a, input logic [1:0] s);
    return ((a >> (ADDR_W + 2)) != 32'd0) || (s == 2'd1 && a[0]) || (s >= 2'd2 && a[1:0] != 2'b00);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      f_hd[k] = 0; f_cnt[k] = 0;
      exp_dok[k] = 1'b0; exp_rdata[k] = 32'd0; exp_err[k] = 1'b0;
    end
  endtask

  // Predict the effect of the coming rising edge on instance k
  task automatic model_edge(input int k);
    logic acc, pp, e_c;
    int slot, w;
    acc = req && (f_cnt[k] < qd_of(k));
    pp  = (f_cnt[k] > 0) && (f_due[k][f_hd[k]] <= edge_no);
    exp_dok[k] = pp;
    if (pp) begin
      exp_rdata[k] = f_data[k][f_hd[k]];
      exp_err[k]   = f_err[k][f_hd[k]];
      f_hd[k]      = (f_hd[k] + 1) % 8;
      f_cnt[k]--;
    end
    if (acc) begin
      e_c  = spec_err(addr, size);
      w    = int'(addr[13:2]) % 16;
      slot = (f_hd[k] + f_cnt[k]) % 8;
      f_err[k][slot]  = e_c;
      f_due[k][slot]  = edge_no + lat_of(k);
      f_data[k][slot] = (wr || e_c) ? 32'd0 : mmem[k][w];
      if (wr && !e_c) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) mmem[k][w][8*b +: 8] = wdata[8*b +: 8];
      end
      f_cnt[k]++;
    end
  endtask

  // One clock cycle: entered and left at a falling edge
  task automatic cycle(input logic r_req, input logic r_wr, input logic [1:0] r_size,
                       input logic [31:0] r_addr, input logic [31:0] r_wdata,
                       input logic [3:0] r_wstrb, input logic r_rst);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("i%0d addr_ok", k), 32'(addr_ok[k]), 32'(!rst && (f_cnt[k] < qd_of(k))));
      check($sformatf("i%0d data_ok", k), 32'(data_ok[k]), 32'(exp_dok[k]));
      check($sformatf("i%0d rdata", k), rdata[k], exp_rdata[k]);
      check($sformatf("i%0d err", k), 32'(err[k]), 32'(exp_err[k]));
    end
    rst = r_rst; req = r_req; wr = r_wr; size = r_size;
    addr = r_addr; wdata = r_wdata; wstrb = r_wstrb;
    if (r_rst) begin
      #1;
      for (int k = 0; k < NI; k++) begin
        check($sformatf("i%0d rst addr_ok", k), 32'(addr_ok[k]), 32'd0);
        check($sformatf("i%0d rst data_ok", k), 32'(data_ok[k]), 32'd0);
      end
      model_reset();
    end else begin
      for (int k = 0; k < NI; k++) model_edge(k);
    end
    @(posedge clk);
    edge_no++;
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0, 1'b0);
  endtask

  function automatic logic busy();
    logic b = 1'b0;
    for (int k = 0; k < NI; k++) if (f_cnt[k] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain();
    for (int i = 0; i < 40 && busy(); i++) idle();
    idle();
  endtask

  // Single request from an empty state; checks instance 0 data and every instance's latency
  task automatic txn_check(input string tag, input logic t_wr, input logic [1:0] t_size,
                           input logic [31:0] t_addr, input logic [31:0] t_wdata,
                           input logic [3:0] t_wstrb, input logic [31:0] x_data, input logic x_err);
    int lat [NI];
    drain();
    for (int k = 0; k < NI; k++) lat[k] = -1;
    cycle(1'b1, t_wr, t_size, t_addr, t_wdata, t_wstrb, 1'b0);
    for (int j = 0; j <= 12; j++) begin
      for (int k = 0; k < NI; k++) begin
        if (data_ok[k] && lat[k] < 0) begin
          lat[k] = j;
          if (k == 0) begin
            check({tag, " rdata"}, rdata[0], x_data);
            check({tag, " err"}, 32'(err[0]), 32'(x_err));
          end
        end
      end
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      idle();
    end
    for (int k = 0; k < NI; k++) check($sformatf("%s latency i%0d", tag, k), 32'(lat[k]), 32'(lat_of(k)));
  endtask

  initial begin
    logic [31:0] got [4];
    int          got_n, idx, pulses;
    logic        acc0, r_rst, r_req, r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;

    model_reset();
    @(negedge clk);
    @(negedge clk);
    idle();

    txn_check("st0", 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
    txn_check("ld0", 1'b0, 2'd2, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0);
    txn_check("st_b1", 1'b1, 2'd0, 32'h11, 32'hAABBCCDD, 4'b0010, 32'd0, 1'b0);
    txn_check("ld_b1", 1'b0, 2'd2, 32'h10, 32'd0, 4'h0, 32'hDEADCCEF, 1'b0);
    txn_check("st_h1", 1'b1, 2'd1, 32'h12, 32'h12340000, 4'b1100, 32'd0, 1'b0);
    txn_check("ld_h1", 1'b0, 2'd2, 32'h10, 32'd0, 4'h0, 32'h1234CCEF, 1'b0);

    for (int w = 0; w < 16; w++) begin
      if (w != 4)
        txn_check("preload", 1'b1, 2'd2, 32'(w * 4), (w < 4) ? 32'(w + 1) : $urandom, 4'hF, 32'd0, 1'b0);
    end

    // Four loads with req held high: queue fills, responses stay in order
    drain();
    got_n = 0; idx = 0;
    for (int t = 0; t < 30 && got_n < 4; t++) begin
      if (data_ok[0]) begin
        got[got_n] = rdata[0];
        got_n++;
      end
      acc0 = (f_cnt[0] < qd_of(0));
      cycle(idx < 4, 1'b0, 2'd2, 32'(idx * 4), 32'd0, 4'h0, 1'b0);
      if (acc0 && idx < 4) idx++;
    end
    check("b2b responses", 32'(got_n), 32'd4);
    for (int i = 0; i < got_n; i++) check($sformatf("b2b rsp%0d", i), got[i], 32'(i + 1));

    txn_check("ld_mis", 1'b0, 2'd2, 32'h6, 32'd0, 4'h0, 32'd0, 1'b1);
    txn_check("st_mis", 1'b1, 2'd1, 32'h3, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1);
    txn_check("ld_w0", 1'b0, 2'd2, 32'h0, 32'd0, 4'h0, 32'd1, 1'b0);
    txn_check("ld_oob", 1'b0, 2'd2, 32'h0001_0000, 32'd0, 4'h0, 32'd0, 1'b1);
    txn_check("ld_sz3", 1'b0, 2'd3, 32'h8, 32'd0, 4'h0, 32'd3, 1'b0);

    // Reset with two loads in flight
    txn_check("st_pre_rst", 1'b1, 2'd2, 32'h14, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0);
    drain();
    cycle(1'b1, 1'b0, 2'd2, 32'h0, 32'd0, 4'h0, 1'b0);
    cycle(1'b1, 1'b0, 2'd2, 32'h4, 32'd0, 4'h0, 1'b0);
    cycle(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 4'h0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (data_ok[0]) pulses++;
    end
    check("rst no data_ok", 32'(pulses), 32'd0);
    txn_check("ld_post_rst", 1'b0, 2'd2, 32'h14, 32'd0, 4'h0, 32'hCAFEF00D, 1'b0);

    // Store then load of the same word on consecutive cycles
    drain();
    cycle(1'b1, 1'b1, 2'd2, 32'h18, 32'h5A5A1234, 4'hF, 1'b0);
    cycle(1'b1, 1'b0, 2'd2, 32'h18, 32'd0, 4'h0, 1'b0);
    req = 1'b0;
    check("l1 store rsp", 32'(data_ok[1]), 32'd1);
    idle();
    check("l1 load rsp", 32'(data_ok[1]), 32'd1);
    check("l1 load data", rdata[1], 32'h5A5A1234);

    // Randomized traffic with occasional reset
    drain();
    for (int n = 0; n < 800; n++) begin
      r_rst  = ($urandom_range(0, 99) == 0);
      r_req  = ($urandom_range(0, 9) < 7);
      r_wr   = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) r_addr = ($urandom & 32'hFFFF_003F) | 32'h0000_4000;
      else                           r_addr = 32'($urandom_range(0, 63));
      cycle(r_req, r_wr, r_size, r_addr, $urandom, 4'($urandom_range(0, 15)), r_rst);
    end
    drain();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
